// File: rtl/agc_scaler_pkg.sv
// agc_scaler_pkg: shared definitions for the binary scaler chain.
//   NSTG_DEF / TMO_CYC_DEF : default stage count and watchdog limit.
//   SCL_MAX_W              : widest stage vector the edge helper handles.
//   scl_vec_t              : stage vector container (FS/FA/FB values are
//                            zero-extended into it).
//   scl_edges(old,new)     : per-bit rise (0->1) and fall (1->0) masks.
package agc_scaler_pkg;

    localparam int NSTG_DEF    = 16;
    localparam int TMO_CYC_DEF = 64;
    localparam int SCL_MAX_W   = 32;

    typedef logic [SCL_MAX_W-1:0] scl_vec_t;

    typedef struct packed {
        scl_vec_t rise;
        scl_vec_t fall;
    } scl_edge_t;

    function automatic scl_edge_t scl_edges(input scl_vec_t old_v, input scl_vec_t new_v);
        scl_edge_t e;
        e.rise = ~old_v & new_v;
        e.fall = old_v & ~new_v;
        return e;
    endfunction

endpackage

// File: rtl/agc_scaler_wdog.sv
// agc_scaler_wdog: FS01 activity watchdog with sticky scaler-fail alarm.
//   CLOCK  : master clock
//   rst    : synchronous active-high reset
//   fs01_q : FS01 as sampled on the previous cycle
//   FS01   : current FS01 level
//   SCAFAL : sticky alarm, set the cycle after the idle count reaches TMO_CYC
// Test hold is intentionally not an input: a stuck FS01 must alarm even
// while the count is frozen.
module agc_scaler_wdog #(
    parameter int TMO_CYC = 64
) (
    input  logic CLOCK,
    input  logic rst,
    input  logic fs01_q,
    input  logic FS01,
    output logic SCAFAL
);

    localparam int WD_W = $clog2(TMO_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TMO_CYC);

    logic [WD_W-1:0] wd;

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            wd     <= '0;
            SCAFAL <= 1'b0;
        end else begin
            if (fs01_q ^ FS01)
                wd <= '0;
            else if (wd != WD_LIM)
                wd <= wd + WD_W'(1);   // saturates at the limit
            if (wd == WD_LIM)
                SCAFAL <= 1'b1;
        end
    end

endmodule

// File: rtl/agc_scaler.sv
// agc_scaler: binary scaler chain after the timer's FS01 stage.
// Counts FS01 falling edges into an NSTG-bit register (FS02..FS(NSTG+1))
// and emits one-cycle per-stage rise (FA) / fall (FB) strobes.
//   CLOCK  : master clock
//   rst    : synchronous active-high reset
//   FS01   : stage-1 level, synchronous to CLOCK
//   SCLHLD : test hold; falling edges seen while high are discarded
//   FS     : stage levels, FS[0] = FS02
//   FA/FB  : one-cycle per-stage rise / fall strobes
//   SCLWRP : one-cycle strobe on all-ones -> zero wrap
//   SCAFAL : sticky scaler-fail alarm (constant 0 unless the watchdog
//            is built in with AGC_SCALER_ALARM_EN)
// No GOJAM/standby clear exists by design: the chain must keep running.
module agc_scaler
    import agc_scaler_pkg::*;
#(
    parameter int NSTG    = NSTG_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic            FS01,
    input  logic            SCLHLD,
    output logic [NSTG-1:0] FS,
    output logic [NSTG-1:0] FA,
    output logic [NSTG-1:0] FB,
    output logic            SCLWRP,
    output logic            SCAFAL
);

    logic            fs01_q;
    logic [NSTG-1:0] count;
    logic [NSTG-1:0] count_nxt;
    logic            adv;
    scl_vec_t        old_v;
    scl_vec_t        new_v;
    scl_edge_t       edges;
    logic            unused_edge_bits;

    assign adv       = fs01_q & ~FS01 & ~SCLHLD;
    assign count_nxt = count + NSTG'(1);

    // Widen into the package container so the shared helper can be used
    // for any NSTG up to SCL_MAX_W; the upper bits are always zero.
    always_comb begin
        old_v             = '0;
        new_v             = '0;
        old_v[NSTG-1:0]   = count;
        new_v[NSTG-1:0]   = count_nxt;
    end

    assign edges            = scl_edges(old_v, new_v);
    assign unused_edge_bits = ^{edges.rise, edges.fall};

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            fs01_q <= 1'b0;
            count  <= '0;
            FA     <= '0;
            FB     <= '0;
            SCLWRP <= 1'b0;
        end else begin
            fs01_q <= FS01;
            if (adv) begin
                count  <= count_nxt;
                FA     <= edges.rise[NSTG-1:0];
                FB     <= edges.fall[NSTG-1:0];
                SCLWRP <= &count;
            end else begin
                FA     <= '0;
                FB     <= '0;
                SCLWRP <= 1'b0;
            end
        end
    end

    assign FS = count;

`ifdef AGC_SCALER_ALARM_EN
    agc_scaler_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .CLOCK  (CLOCK),
        .rst    (rst),
        .fs01_q (fs01_q),
        .FS01   (FS01),
        .SCAFAL (SCAFAL)
    );
`else
    localparam int unused_tmo = TMO_CYC;
    assign SCAFAL = 1'b0;
`endif

endmodule

// File: tb/tb_agc_scaler.sv
module tb_agc_scaler;

    localparam int TMO = 64;
`ifdef AGC_SCALER_ALARM_EN
    localparam bit ALM_EN = 1'b1;
`else
    localparam bit ALM_EN = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        rst   = 1'b1;
    logic        FS01  = 1'b0;
    logic        SCLHLD = 1'b0;
    logic [15:0] fs_a, fa_a, fb_a;
    logic [3:0]  fs_b, fa_b, fb_b;
    logic        wrp_a, wrp_b, alm_a, alm_b;

    always #5 CLOCK = ~CLOCK;

    agc_scaler #(.NSTG(16), .TMO_CYC(TMO)) dut_a (
        .CLOCK(CLOCK), .rst(rst), .FS01(FS01), .SCLHLD(SCLHLD),
        .FS(fs_a), .FA(fa_a), .FB(fb_a), .SCLWRP(wrp_a), .SCAFAL(alm_a));

    agc_scaler #(.NSTG(4), .TMO_CYC(TMO)) dut_b (
        .CLOCK(CLOCK), .rst(rst), .FS01(FS01), .SCLHLD(SCLHLD),
        .FS(fs_b), .FA(fa_b), .FB(fb_b), .SCLWRP(wrp_b), .SCAFAL(alm_b));

    int checks = 0;
    int errors = 0;

    // Reference model: a plain counter of accepted falls per width, with
    // strobes derived from how many low-order ones the old value carried.
    int m_w[2] = '{16, 4};
    int m_fs[2], m_fa[2], m_fb[2], m_wrp[2];
    int m_prev, m_idle, m_alm;

    function automatic int trailing_ones(input int v, input int w);
        int t = 0;
        while (t < w && v[t]) t++;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int f, input int h, input int r);
        int t;
        bit adv;
        if (r != 0) begin
            m_prev = 0; m_idle = 0; m_alm = 0;
            for (int d = 0; d < 2; d++) begin
                m_fs[d] = 0; m_fa[d] = 0; m_fb[d] = 0; m_wrp[d] = 0;
            end
        end else begin
            if (m_idle >= TMO) m_alm = 1;
            if (f != m_prev) m_idle = 0; else m_idle++;
            adv = (m_prev == 1) && (f == 0) && (h == 0);
            for (int d = 0; d < 2; d++) begin
                if (adv) begin
                    t        = trailing_ones(m_fs[d], m_w[d]);
                    m_fs[d]  = (m_fs[d] + 1) % (1 << m_w[d]);
                    m_fa[d]  = (t == m_w[d]) ? 0 : (1 << t);
                    m_fb[d]  = (1 << t) - 1;
                    m_wrp[d] = (t == m_w[d]) ? 1 : 0;
                end else begin
                    m_fa[d] = 0; m_fb[d] = 0; m_wrp[d] = 0;
                end
            end
            m_prev = f;
        end
    endtask

    task automatic check_all();
        chk("fs16",  32'(fs_a),  32'(m_fs[0]));
        chk("fa16",  32'(fa_a),  32'(m_fa[0]));
        chk("fb16",  32'(fb_a),  32'(m_fb[0]));
        chk("wrp16", 32'(wrp_a), 32'(m_wrp[0]));
        chk("alm16", 32'(alm_a), ALM_EN ? 32'(m_alm) : 32'd0);
        chk("fs4",   32'(fs_b),  32'(m_fs[1]));
        chk("fa4",   32'(fa_b),  32'(m_fa[1]));
        chk("fb4",   32'(fb_b),  32'(m_fb[1]));
        chk("wrp4",  32'(wrp_b), 32'(m_wrp[1]));
        chk("alm4",  32'(alm_b), ALM_EN ? 32'(m_alm) : 32'd0);
    endtask

    task automatic step(input logic f, input logic h, input logic r);
        @(negedge CLOCK);
        FS01 = f; SCLHLD = h; rst = r;
        @(posedge CLOCK);
        model_update(int'(f), int'(h), int'(r));
        #1;
        check_all();
    endtask

    task automatic adv_once(input logic h);
        step(1'b1, h, 1'b0);
        step(1'b0, h, 1'b0);
    endtask

    initial begin
        int base;

        // Reset held 3 cycles while FS01 toggles every 5 cycles.
        for (int c = 0; c < 6; c++) begin
            step(((c / 5) % 2) == 0, 1'b0, c < 3);
            if (c < 3) begin
                chk("rst_fs", 32'(fs_a), 32'd0);
                chk("rst_fa", 32'(fa_a), 32'd0);
            end
        end
        chk("first_fall_fs", 32'(fs_a), 32'h1);
        chk("first_fall_fa", 32'(fa_a), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        chk("first_fall_fa_one_cycle", 32'(fa_a), 32'h0);

        // Carry chain: 8 advances total from reset.
        for (int k = 0; k < 7; k++) adv_once(1'b0);
        chk("carry_fs", 32'(fs_a), 32'h8);
        chk("carry_fa", 32'(fa_a), 32'h8);
        chk("carry_fb", 32'(fb_a), 32'h7);

        // Wrap of the 4-stage instance on the 16th advance.
        for (int k = 0; k < 8; k++) adv_once(1'b0);
        chk("wrap_fs4",  32'(fs_b),  32'h0);
        chk("wrap_fb4",  32'(fb_b),  32'hF);
        chk("wrap_fa4",  32'(fa_b),  32'h0);
        chk("wrap_wrp4", 32'(wrp_b), 32'h1);
        chk("wrap16_fs", 32'(fs_a),  32'h10);
        chk("wrap16_wrp", 32'(wrp_a), 32'h0);

        // Hold discards falls; next fall after release counts once.
        base = m_fs[0];
        for (int k = 0; k < 2; k++) begin
            adv_once(1'b1);
            chk("hold_fs", 32'(fs_a), 32'(base));
            chk("hold_fa", 32'(fa_a), 32'h0);
            chk("hold_fb", 32'(fb_a), 32'h0);
        end
        adv_once(1'b0);
        chk("hold_resume_fs", 32'(fs_a), 32'(base + 1));

        // Randomised levels and hold, every cycle checked against the model.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(1)), $urandom_range(3) == 0, 1'b0);

        // Reset colliding with an advance at FS = 0xA5.
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 'hA5; k++) adv_once(1'b0);
        chk("coll_pre_fs", 32'(fs_a), 32'hA5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("coll_fs",  32'(fs_a),  32'h0);
        chk("coll_fa",  32'(fa_a),  32'h0);
        chk("coll_fb",  32'(fb_a),  32'h0);
        chk("coll_wrp", 32'(wrp_a), 32'h0);
        step(1'b0, 1'b0, 1'b0);

        // Alarm: FS01 stuck high after a single transition (cycle 0).
        step(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 65; k++) begin
            step(1'b1, k[0], 1'b0);
            if (k == 64) chk("alm_c64", 32'(alm_a), 32'h0);
            if (k == 65) chk("alm_c65", 32'(alm_a), ALM_EN ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < 10; k++) step(k[0], 1'b0, 1'b0);
        chk("alm_sticky", 32'(alm_a), ALM_EN ? 32'h1 : 32'h0);
        step(1'b0, 1'b0, 1'b1);
        chk("alm_rst", 32'(alm_a), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        adv_once(1'b0);
        chk("post_rst_fs", 32'(fs_a), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
